// File: rtl/alu_sliced_unit.sv
// Multi-cycle Y86-64 ALU (ADD/SUB/AND/XOR/NOT/NEG). The datapath handles one SLICE-bit chunk per clock
// and ripples the carry between chunks. Valid/ready handshakes on both sides; ZF/SF/OF flags and an illegal-op error.
module alu_sliced_unit #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             err
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd5;

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("alu_sliced_unit: SLICE must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zf_reg, sf_reg, of_reg, err_reg, out_valid_reg;

    logic [SLICE-1:0] a_sl [N];
    logic [SLICE-1:0] b_sl [N];
    logic [SLICE-1:0] a_cur, b_cur, x_sl, y_sl, slice_val;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] result_next;
    logic             illegal, zf_next, sf_next, of_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
            // Only the slice addressed by cnt changes; the rest keep their earlier values.
            assign result_next[gi*SLICE +: SLICE] = (cnt_reg == CW'(gi)) ? slice_val
                                                                          : result_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    assign a_cur   = a_sl[cnt_reg];
    assign b_cur   = b_sl[cnt_reg];
    assign illegal = op_reg[2] & op_reg[1];

    always_comb begin
        x_sl      = '0;
        y_sl      = '0;
        slice_val = '0;
        unique case (op_reg)
            OP_ADD: begin x_sl = b_cur; y_sl = a_cur;  end
            OP_SUB: begin x_sl = b_cur; y_sl = ~a_cur; end
            OP_NEG: begin x_sl = '0;    y_sl = ~a_cur; end
            default: ;
        endcase
        sum = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, carry_reg};
        unique case (op_reg)
            OP_ADD, OP_SUB, OP_NEG: slice_val = sum[SLICE-1:0];
            OP_AND:                 slice_val = a_cur & b_cur;
            OP_XOR:                 slice_val = a_cur ^ b_cur;
            OP_NOT:                 slice_val = ~a_cur;
            default:                slice_val = '0;
        endcase
    end

    always_comb begin
        zf_next = (result_next == '0) && !illegal;
        sf_next = result_next[WIDTH-1];
        unique case (op_reg)
            OP_ADD:  of_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (result_next[WIDTH-1] != a_reg[WIDTH-1]);
            OP_SUB:  of_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (result_next[WIDTH-1] != b_reg[WIDTH-1]);
            OP_NEG:  of_next = (a_reg == {1'b1, {(WIDTH-1){1'b0}}});
            default: of_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zf_reg        <= 1'b0;
            sf_reg        <= 1'b0;
            of_reg        <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg    <= op;
                        a_reg     <= a;
                        b_reg     <= b;
                        cnt_reg   <= '0;
                        carry_reg <= (op == OP_SUB) || (op == OP_NEG);
                        if (!(op[2] & op[1])) begin
                            err_reg <= 1'b0;
                        end
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    result_reg <= result_next;
                    carry_reg  <= sum[SLICE];
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        zf_reg        <= zf_next;
                        sf_reg        <= sf_next;
                        of_reg        <= of_next;
                        err_reg       <= illegal;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zf        = zf_reg;
    assign sf        = sf_reg;
    assign of        = of_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_sliced_unit.sv
// Scoreboard bench for alu_sliced_unit: a 32/8 instance and a 64/16 instance,
// directed vectors pushed on accept and popped by per-instance monitors.
module tb_alu_sliced_unit;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] res;
        logic        zf, sf, of, err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q32[$];
    exp_t q64[$];

    logic        v32, rdy32, ov32, ordy32, zf32, sf32, of32, err32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;

    logic        v64, rdy64, ov64, ordy64, zf64, sf64, of64, err64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, res64;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sliced_unit #(.WIDTH(32), .SLICE(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .op(op32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(ordy32), .result(res32), .zf(zf32), .sf(sf32), .of(of32), .err(err32)
    );

    alu_sliced_unit #(.WIDTH(64), .SLICE(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .op(op64), .a(a64), .b(b64),
        .out_valid(ov64), .out_ready(ordy64), .result(res64), .zf(zf64), .sf(sf64), .of(of64), .err(err64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitors: latency checked when out_valid first appears, data checked on the handshake.
    bit seen32 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (ov32 && !seen32) begin
            seen32 = 1;
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL w32_unexpected: out_valid with empty scoreboard");
            end else begin
                chk("w32_latency", 64'(cyc - q32[0].acc), 64'd4);
            end
        end
        if (ov32 && ordy32) begin
            seen32 = 0;
            if (q32.size() != 0) begin
                e = q32.pop_front();
                $display("[w32] cyc=%0d op=%0d result=%h zf=%b sf=%b of=%b err=%b",
                         cyc, e.op, res32, zf32, sf32, of32, err32);
                chk("w32_result", {32'h0, res32}, e.res);
                chk("w32_zf", 64'(zf32), 64'(e.zf));
                chk("w32_sf", 64'(sf32), 64'(e.sf));
                chk("w32_of", 64'(of32), 64'(e.of));
                chk("w32_err", 64'(err32), 64'(e.err));
            end
        end
    end

    bit seen64 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (ov64 && !seen64) begin
            seen64 = 1;
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL w64_unexpected: out_valid with empty scoreboard");
            end else begin
                chk("w64_latency", 64'(cyc - q64[0].acc), 64'd4);
            end
        end
        if (ov64 && ordy64) begin
            seen64 = 0;
            if (q64.size() != 0) begin
                e = q64.pop_front();
                $display("[w64] cyc=%0d op=%0d result=%h zf=%b sf=%b of=%b err=%b",
                         cyc, e.op, res64, zf64, sf64, of64, err64);
                chk("w64_result", res64, e.res);
                chk("w64_zf", 64'(zf64), 64'(e.zf));
                chk("w64_sf", 64'(sf64), 64'(e.sf));
                chk("w64_of", 64'(of64), 64'(e.of));
                chk("w64_err", 64'(err64), 64'(e.err));
            end
        end
    end

    task automatic issue32(input logic [2:0] o, input logic [31:0] aa, input logic [63:0] er,
                           input logic ezf, input logic esf);
        exp_t e;
        int t = 0;
        @(negedge clk);
        v32 = 1'b1; op32 = o; a32 = aa; b32 = 32'h0;
        while (!rdy32 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin errors++; $display("FAIL w32_accept: got timeout expected in_ready"); end
        @(posedge clk); #1;
        v32 = 1'b0;
        e.op = o; e.res = er; e.zf = ezf; e.sf = esf; e.of = 1'b0; e.err = 1'b0; e.acc = cyc;
        q32.push_back(e);
    endtask

    task automatic issue64(input logic [2:0] o, input logic [63:0] aa, input logic [63:0] bb,
                           input logic [63:0] er, input logic ezf, input logic esf,
                           input logic eof, input logic eerr, input bit push);
        exp_t e;
        int t = 0;
        @(negedge clk);
        v64 = 1'b1; op64 = o; a64 = aa; b64 = bb;
        while (!rdy64 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin errors++; $display("FAIL w64_accept: got timeout expected in_ready"); end
        @(posedge clk); #1;
        v64 = 1'b0;
        e.op = o; e.res = er; e.zf = ezf; e.sf = esf; e.of = eof; e.err = eerr; e.acc = cyc;
        if (push) q64.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while ((q32.size() != 0 || q64.size() != 0) && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) begin errors++; $display("FAIL drain: got %0d pending expected 0", q32.size() + q64.size()); end
    endtask

    initial begin
        logic [63:0] hold_res;
        logic [3:0]  hold_flags;
        int t;
        rst = 1'b1;
        v32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; ordy32 = 1'b1;
        v64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; ordy64 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(ov64), 64'd0);
        chk("reset_result", res64, 64'd0);
        chk("reset_flags", 64'({zf64, sf64, of64, err64}), 64'd0);
        chk("reset_in_ready_low", 64'(rdy64), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'({rdy32, rdy64}), 64'd3);

        // 32/8 NOT vectors
        issue32(3'd4, 32'h0000000B, 64'hFFFFFFF4, 1'b0, 1'b1);
        issue32(3'd4, 32'hFFFFFFF5, 64'h0000000A, 1'b0, 1'b0);
        issue32(3'd4, 32'hFFFFFFFE, 64'h00000001, 1'b0, 1'b0);

        // 64/16 arithmetic and logic vectors
        issue64(3'd0, 64'h000000000000FFFF, 64'd1, 64'h0000000000010000, 0, 0, 0, 0, 1);
        issue64(3'd1, 64'd1, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0, 0, 1);
        issue64(3'd1, 64'd1, 64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 0, 0, 1, 0, 1);
        issue64(3'd5, 64'h8000000000000000, 64'd0, 64'h8000000000000000, 0, 1, 1, 0, 1);
        issue64(3'd5, 64'd1, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0, 0, 1);
        issue64(3'd3, 64'h1234, 64'h1234, 64'd0, 1, 0, 0, 0, 1);
        issue64(3'd2, 64'hF0F0, 64'hFF00, 64'hF000, 0, 0, 0, 0, 1);
        issue64(3'd0, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, 0, 1, 1, 0, 1);
        issue64(3'd7, 64'd5, 64'd3, 64'd0, 0, 0, 0, 1, 1);
        issue64(3'd0, 64'd2, 64'd3, 64'd5, 0, 0, 0, 0, 1);
        issue64(3'd6, 64'hFFFF, 64'hFFFF, 64'd0, 0, 0, 0, 1, 1);
        drain();

        // Backpressure: hold out_ready low for 5 cycles with in_valid asserted
        ordy64 = 1'b0;
        issue64(3'd0, 64'h0000000100000000, 64'h00000000FFFFFFFF, 64'h00000001FFFFFFFF, 0, 0, 0, 0, 1);
        t = 0;
        while (!ov64 && t < 50) begin @(negedge clk); t++; end
        chk("bp_valid_seen", 64'(ov64), 64'd1);
        hold_res = res64;
        hold_flags = {zf64, sf64, of64, err64};
        v64 = 1'b1; op64 = 3'd1; a64 = 64'd9; b64 = 64'd1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_result_hold", res64, hold_res);
            chk("bp_flags_hold", 64'({zf64, sf64, of64, err64}), 64'(hold_flags));
            chk("bp_ctrl", 64'({ov64, rdy64}), 64'b10);
        end
        v64 = 1'b0;
        @(posedge clk); #1;
        ordy64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release", 64'({ov64, rdy64}), 64'b01);

        // Reset while BUSY with cnt==2: nothing pushed, so any output is flagged by the monitor
        issue64(3'd0, 64'h0001000100010001, 64'h0001000100010001, 64'd0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_result", res64, 64'd0);
        chk("rst_mid_flags", 64'({ov64, zf64, sf64, of64, err64}), 64'd0);
        chk("rst_mid_in_ready", 64'(rdy64), 64'd1);
        repeat (8) @(negedge clk);
        chk("rst_mid_no_output", 64'(ov64), 64'd0);

        issue64(3'd1, 64'd3, 64'd10, 64'd7, 0, 0, 0, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
